// File: rtl/ram_dump_engine_pkg.sv
// Shared types and constants for the RAM dump engine.
package ram_dump_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} dump_state_t;

  // Supported RAM read-latency range.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Output buffer depth: one slot per in-flight read, plus one for the word
  // being presented. This sustains one word per cycle at any latency.
  function automatic int dump_depth(input int lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/ram_dump_engine_if.sv
// Command, RAM and output-stream signals of the dump engine.
interface ram_dump_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  // Engine side.
  modport master (
    input  start, base_addr, count, mem_readdata, out_ready,
    output busy, done, mem_address, mem_read, mem_write, mem_writedata,
           out_valid, out_addr, out_data
  );

  // Environment side: command source, RAM and consumer.
  modport slave (
    output start, base_addr, count, mem_readdata, out_ready,
    input  busy, done, mem_address, mem_read, mem_write, mem_writedata,
           out_valid, out_addr, out_data
  );
endinterface

// File: rtl/ram_dump_engine_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Head data reads as zero while empty so the outputs are clean after reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

  // Storage write; the caller never pushes into a full buffer.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers and occupancy, wrapping at DEPTH (not necessarily a power of 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + AW'(1);
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ram_dump_engine.sv
// Memory-sweep engine: reads count words from base_addr and streams
// (address, data) pairs, throttled by a credit check so the output buffer
// can always absorb every read that is in flight.
module ram_dump_engine
  import ram_dump_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  ram_dump_engine_if.master bus
);
  localparam int DEPTH = dump_depth(READ_LATENCY);
  localparam int FW    = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int OW    = 4;  // holds inflight + fifo count (at most 2*LAT_MAX+1)

  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
    $error("ram_dump_engine: READ_LATENCY must be in 1..4");
  end

  dump_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_issue_left;
  logic [ADDR_WIDTH:0]   r_out_left;
  logic                  r_done;
  logic [READ_LATENCY-1:0] r_vld_pipe;
  logic [ADDR_WIDTH-1:0] r_addr_pipe [READ_LATENCY];

  logic          w_issue, w_load, w_done_nxt, w_pop, w_credit_ok;
  logic [OW-1:0] w_inflight;
  logic [CW-1:0] w_fifo_cnt;
  logic          w_fifo_valid;
  logic [FW-1:0] w_fifo_rdata;

  // Count reads issued but not yet landed in the output buffer.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + OW'(r_vld_pipe[i]);
  end

  assign w_pop       = w_fifo_valid & bus.out_ready;
  // inflight + fifo_count - pop < DEPTH, rearranged to avoid subtraction.
  assign w_credit_ok = (w_inflight + OW'(w_fifo_cnt)) < (OW'(DEPTH) + OW'(w_pop));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state, read issue and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            w_load      = 1'b1;
            w_state_nxt = SWEEP;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_issue_left == (ADDR_WIDTH+1)'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && r_out_left == (ADDR_WIDTH+1)'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address counter, issue/output counters and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_addr       <= bus.base_addr;
        r_issue_left <= bus.count;
        r_out_left   <= bus.count;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + ADDR_WIDTH'(1);
          r_issue_left <= r_issue_left - (ADDR_WIDTH+1)'(1);
        end
        if (w_pop) r_out_left <= r_out_left - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Valid bits of in-flight reads; flushed on reset so late data is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // Addresses travelling alongside the valid bits.
  always_ff @(posedge clk) begin
    r_addr_pipe[0] <= r_addr;
    for (int i = 1; i < READ_LATENCY; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_vld_pipe[READ_LATENCY-1]),
    .i_wdata ({r_addr_pipe[READ_LATENCY-1], bus.mem_readdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_cnt)
  );

  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = r_done;
  assign bus.mem_address   = r_addr;
  assign bus.mem_read      = w_issue;
  assign bus.mem_write     = 1'b0;
  assign bus.mem_writedata = '0;
  assign bus.out_valid     = w_fifo_valid;
  assign {bus.out_addr, bus.out_data} = w_fifo_rdata;
endmodule
